grasspopper_key_schedule: RTL and testbench

Kuznyechik (GOST R 34.12-2015) round-key expansion unit, directly upstream of the grasspopper cipher core. It accepts a 256-bit master key and runs the 32-round Feistel key schedule iteratively. It stores the ten 128-bit round keys K1..K10, which the core reads by index.

---
 rtl/grasspopper_pkg.sv | 97 +++++++++
 rtl/grasspopper_key_schedule_if.sv | 21 ++
 rtl/grasspopper_r_step.sv | 17 +
 rtl/grasspopper_key_schedule.sv | 141 ++++++++++++++
 tb/tb_grasspopper_key_schedule.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/grasspopper_pkg.sv
// Shared Kuznyechik definitions: the pi S-box, the l coefficients,
// GF(2^8) multiply, the iteration-constant table C and the FSM states.
package grasspopper_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SX,
        LR
    } ks_state_e;

    localparam logic [7:0] PI [256] = '{
        8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,
        8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
        8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186,
        8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
        8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,
        8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
        8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160,
        8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
        8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171,
        8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
        8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,
        8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
        8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199,
        8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
        8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126,
        8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
        8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201,
        8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
        8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188,
        8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
        8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,
        8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
        8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,
        8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
        8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247,
        8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
        8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254,
        8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
        8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,
        8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
        8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192,
        8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
    };

    // L_COEF[i] multiplies byte a_i (a0 = least significant byte)
    localparam logic [15:0][7:0] L_COEF = {
        8'd148, 8'd32,  8'd133, 8'd16,
        8'd194, 8'd192, 8'd1,   8'd251,
        8'd1,   8'd192, 8'd194, 8'd16,
        8'd133, 8'd32,  8'd148, 8'd1
    };

    // Multiply in GF(2^8) modulo x^8+x^7+x^6+x+1
    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            if (x[7]) x = {x[6:0], 1'b0} ^ 8'hC3;
            else      x = {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] l_fn(input logic [127:0] v);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++)
            acc = acc ^ gf_mul(L_COEF[i], v[8*i +: 8]);
        return acc;
    endfunction

    // Elaboration-time only: builds the constant table, no hardware
    function automatic logic [31:0][127:0] c_gen();
        logic [31:0][127:0] c;
        logic [127:0]       v;
        for (int i = 0; i < 32; i++) begin
            v = 128'(i + 1);
            for (int k = 0; k < 16; k++)
                v = {l_fn(v), v[127:8]};
            c[i] = v;
        end
        return c;
    endfunction

    localparam logic [31:0][127:0] C_TAB = c_gen();

endpackage

// File: rtl/grasspopper_key_schedule_if.sv
// Key-schedule bus: start request, master key, status and round-key read.
// master = key source / consumer, slave = key schedule unit.
interface grasspopper_key_schedule_if;
    logic         key_valid;
    logic [255:0] key_i;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rk_addr;
    logic [127:0] rk_o;

    modport master (
        output key_valid, key_i, rk_addr,
        input  busy, done, keys_valid, rk_o
    );

    modport slave (
        input  key_valid, key_i, rk_addr,
        output busy, done, keys_valid, rk_o
    );
endinterface

// File: rtl/grasspopper_r_step.sv
// One combinational Kuznyechik R transform: d_o = l(d_i) || d_i[127:8].
// Ports: d_i 128-bit input block, d_o 128-bit transformed block.
module grasspopper_r_step
    import grasspopper_pkg::*;
(
    input  logic [127:0] d_i,
    output logic [127:0] d_o
);
    logic [7:0] l_byte;

    always_comb begin
        l_byte = '0;
        for (int i = 0; i < 16; i++)
            l_byte = l_byte ^ gf_mul(L_COEF[i], d_i[8*i +: 8]);
        d_o = {l_byte, d_i[127:8]};
    end
endmodule

// File: rtl/grasspopper_key_schedule.sv
// Iterative Kuznyechik key expansion: 32 Feistel rounds, 10 round keys.
// Ports: clk, reset (sync, high), bus = slave side of the key bus.
module grasspopper_key_schedule
    import grasspopper_pkg::*;
#(
    parameter int R_PER_CYCLE = 1
) (
    input logic                         clk,
    input logic                         reset,
    grasspopper_key_schedule_if.slave   bus
);
    localparam int         LCYC  = 16 / R_PER_CYCLE;
    localparam logic [3:0] LLAST = 4'(LCYC - 1);

    ks_state_e    state_q, state_d;
    logic [4:0]   round_q, round_d;
    logic [3:0]   lcnt_q, lcnt_d;
    logic [127:0] a_q, a_d;
    logic [127:0] b_q, b_d;
    logic [127:0] t_q, t_d;
    logic [127:0] rk_q [10];
    logic [127:0] rk_d [10];
    logic [127:0] rk_o_q, rk_o_d;
    logic         done_q, done_d;
    logic         kv_q, kv_d;

    logic [127:0] sx_in;
    logic [127:0] sx_out;
    logic [127:0] chain [R_PER_CYCLE + 1];
    logic [127:0] a_new;

    assign chain[0] = t_q;

    for (genvar g = 0; g < R_PER_CYCLE; g++) begin : g_r
        grasspopper_r_step u_r (
            .d_i (chain[g]),
            .d_o (chain[g + 1])
        );
    end

    // Feistel F-output xor right half, used on the last L cycle
    assign a_new = chain[R_PER_CYCLE] ^ b_q;

    always_comb begin
        sx_out = '0;
        sx_in  = a_q ^ C_TAB[round_q];
        for (int i = 0; i < 16; i++)
            sx_out[8*i +: 8] = PI[sx_in[8*i +: 8]];
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        lcnt_d  = lcnt_q;
        a_d     = a_q;
        b_d     = b_q;
        t_d     = t_q;
        rk_d    = rk_q;
        done_d  = 1'b0;
        kv_d    = kv_q;
        rk_o_d  = '0;
        for (int i = 0; i < 10; i++)
            if (bus.rk_addr == 4'(i)) rk_o_d = rk_q[i];

        unique case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    a_d     = bus.key_i[255:128];
                    b_d     = bus.key_i[127:0];
                    rk_d[0] = bus.key_i[255:128];
                    rk_d[1] = bus.key_i[127:0];
                    round_d = '0;
                    kv_d    = 1'b0;
                    state_d = SX;
                end
            end
            SX: begin
                t_d     = sx_out;
                lcnt_d  = '0;
                state_d = LR;
            end
            LR: begin
                t_d    = chain[R_PER_CYCLE];
                lcnt_d = lcnt_q + 4'd1;
                if (lcnt_q == LLAST) begin
                    a_d     = a_new;
                    b_d     = a_q;
                    round_d = round_q + 5'd1;
                    // Every 8th round yields the next round-key pair
                    if (round_q[2:0] == 3'd7) begin
                        for (int j = 0; j < 4; j++) begin
                            if (round_q[4:3] == 2'(j)) begin
                                rk_d[2 + 2*j] = a_new;
                                rk_d[3 + 2*j] = a_q;
                            end
                        end
                    end
                    if (round_q == 5'd31) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        kv_d    = 1'b1;
                    end else begin
                        state_d = SX;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= '0;
            lcnt_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            t_q     <= '0;
            for (int i = 0; i < 10; i++) rk_q[i] <= '0;
            rk_o_q  <= '0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            lcnt_q  <= lcnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            t_q     <= t_d;
            rk_q    <= rk_d;
            rk_o_q  <= rk_o_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.keys_valid = kv_q;
    assign bus.rk_o       = rk_o_q;
endmodule

// File: tb/tb_grasspopper_key_schedule.sv
// Testbench for grasspopper_key_schedule (R_PER_CYCLE 1 and 16)
// and the standalone grasspopper_r_step.
module tb_grasspopper_key_schedule;
    import grasspopper_pkg::*;

    typedef logic [127:0] keys_t [10];
    typedef struct {
        string        name;
        logic [3:0]   addr;
        logic [127:0] exp;
    } vec_t;

    localparam logic [255:0] RFC_KEY =
        256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grasspopper_key_schedule_if b1 ();
    grasspopper_key_schedule_if b16 ();

    grasspopper_key_schedule #(.R_PER_CYCLE(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    grasspopper_key_schedule #(.R_PER_CYCLE(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (b16.slave)
    );

    logic [127:0] rs_in;
    logic [127:0] rs_out;
    grasspopper_r_step u_rs (
        .d_i (rs_in),
        .d_o (rs_out)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_mul(logic [7:0] x, logic [7:0] y);
        logic [8:0] p;
        p = '0;
        for (int i = 7; i >= 0; i--) begin
            p = {p[7:0], 1'b0};
            if (p[8]) p = p ^ 9'h1C3;
            if (y[i]) p = p ^ {1'b0, x};
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] m_L(logic [127:0] v);
        int coef [16] = '{148, 32, 133, 16, 194, 192, 1, 251,
                          1, 192, 194, 16, 133, 32, 148, 1};
        logic [7:0] l;
        for (int r = 0; r < 16; r++) begin
            l = '0;
            for (int i = 0; i < 16; i++)
                l = l ^ m_mul(8'(coef[15 - i]), v[8*i +: 8]);
            v = {l, v[127:8]};
        end
        return v;
    endfunction

    function automatic logic [127:0] m_S(logic [127:0] v);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = PI[v[8*i +: 8]];
        return o;
    endfunction

    task automatic model(input logic [255:0] key, output keys_t k);
        logic [127:0] a, b, t;
        a = key[255:128];
        b = key[127:0];
        k[0] = a;
        k[1] = b;
        for (int i = 0; i < 32; i++) begin
            t = m_L(m_S(a ^ m_L(128'(i + 1)))) ^ b;
            b = a;
            a = t;
            if (i % 8 == 7) begin
                k[2 + 2*(i/8)] = a;
                k[3 + 2*(i/8)] = b;
            end
        end
    endtask

    // ---------------- DUT access helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_kv(int sel, logic v, logic [255:0] k);
        if (sel == 16) begin
            b16.key_valid = v;
            b16.key_i     = k;
        end else begin
            b1.key_valid = v;
            b1.key_i     = k;
        end
    endtask

    function automatic logic get_busy(int sel);
        return (sel == 16) ? b16.busy : b1.busy;
    endfunction

    function automatic logic get_done(int sel);
        return (sel == 16) ? b16.done : b1.done;
    endfunction

    task automatic read_rk(int sel, logic [3:0] addr, output logic [127:0] v);
        if (sel == 16) b16.rk_addr = addr;
        else           b1.rk_addr  = addr;
        tick();
        v = (sel == 16) ? b16.rk_o : b1.rk_o;
    endtask

    // Runs from the cycle after acceptance; n = edges since the accept
    // edge (inclusive) when done is seen, nb = busy cycles observed.
    task automatic wait_done(int sel, int kv_at, logic [255:0] key2,
                             output int n, output int nb);
        n  = 1;
        nb = 0;
        while (n < 2000) begin
            if (get_busy(sel)) nb++;
            if (get_done(sel)) break;
            if (n == kv_at) set_kv(sel, 1'b1, key2);
            tick();
            if (n == kv_at) set_kv(sel, 1'b0, key2);
            n++;
        end
        chk("no_timeout", 128'(n < 2000), 128'd1);
    endtask

    task automatic run_key(int sel, logic [255:0] key, int kv_at,
                           logic [255:0] key2, output int n, output int nb);
        set_kv(sel, 1'b1, key);
        tick();
        set_kv(sel, 1'b0, key);
        wait_done(sel, kv_at, key2, n, nb);
    endtask

    task automatic check_keys(int sel, string nm, keys_t exp);
        logic [127:0] v;
        for (int i = 0; i < 10; i++) begin
            read_rk(sel, 4'(i), v);
            chk($sformatf("%s_k%0d", nm, i + 1), v, exp[i]);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t  tab [8];
        keys_t rfc_m, ka, kb;
        logic [255:0] key_a, key_b;
        logic [127:0] v;
        int n, nb;

        tab[0] = '{"rfc_k1", 4'd0, 128'h8899aabbccddeeff0011223344556677};
        tab[1] = '{"rfc_k2", 4'd1, 128'hfedcba98765432100123456789abcdef};
        tab[2] = '{"rfc_k3", 4'd2, 128'hdb31485315694343228d6aef8cc78c44};
        tab[3] = '{"rfc_k4", 4'd3, 128'h3d4553d8e9cfec6815ebadc40a9ffd04};
        tab[4] = '{"rfc_k9", 4'd8, 128'hbb44e25378c73123a5f32f73cdb6e517};
        tab[5] = '{"rfc_k10", 4'd9, 128'h72e9dd7416bcf45b755dbaa88e4a4043};
        tab[6] = '{"addr12_zero", 4'd12, 128'h0};
        tab[7] = '{"addr15_zero", 4'd15, 128'h0};

        reset = 1'b1;
        set_kv(1, 1'b0, '0);
        set_kv(16, 1'b0, '0);
        b1.rk_addr  = '0;
        b16.rk_addr = '0;
        rs_in = 128'h00000000000000000000000000000100;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_busy", 128'(b1.busy), 128'd0);
        chk("rst_done", 128'(b1.done), 128'd0);
        chk("rst_kv", 128'(b1.keys_valid), 128'd0);
        chk("rst_rk_o", b1.rk_o, 128'd0);
        chk("r_step", rs_out, 128'h94000000000000000000000000000001);

        // model agrees with the published round keys
        model(RFC_KEY, rfc_m);
        for (int i = 0; i < 6; i++)
            chk({"model_", tab[i].name}, rfc_m[tab[i].addr], tab[i].exp);

        // RFC run, R_PER_CYCLE=1
        run_key(1, RFC_KEY, -1, '0, n, nb);
        chk("r1_done_latency", 128'(n), 128'd545);
        chk("r1_busy_cycles", 128'(nb), 128'd544);
        chk("r1_done_busy_low", 128'(b1.busy), 128'd0);
        chk("r1_kv_at_done", 128'(b1.keys_valid), 128'd1);
        tick();
        chk("r1_done_pulse", 128'(b1.done), 128'd0);
        for (int i = 0; i < 8; i++) begin
            read_rk(1, tab[i].addr, v);
            chk(tab[i].name, v, tab[i].exp);
        end
        check_keys(1, "r1_rfc", rfc_m);

        // RFC run, R_PER_CYCLE=16
        run_key(16, RFC_KEY, -1, '0, n, nb);
        chk("r16_done_latency", 128'(n), 128'd65);
        chk("r16_busy_cycles", 128'(nb), 128'd64);
        check_keys(16, "r16_rfc", rfc_m);

        // second key_valid at cycle 100 is ignored
        key_a = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
        key_b = ~key_a;
        model(key_a, ka);
        run_key(1, key_a, 100, key_b, n, nb);
        chk("ign_latency", 128'(n), 128'd545);
        check_keys(1, "ign", ka);

        // key_valid in the done cycle starts a new run
        model(key_b, kb);
        run_key(1, key_a, -1, '0, n, nb);
        chk("dc_kv_high", 128'(b1.keys_valid), 128'd1);
        set_kv(1, 1'b1, key_b);
        tick();
        set_kv(1, 1'b0, key_b);
        chk("dc_kv_drop", 128'(b1.keys_valid), 128'd0);
        chk("dc_busy", 128'(b1.busy), 128'd1);
        wait_done(1, -1, '0, n, nb);
        chk("dc_latency", 128'(n), 128'd545);
        check_keys(1, "dc", kb);

        // reset in the middle of a run
        set_kv(1, 1'b1, RFC_KEY);
        tick();
        set_kv(1, 1'b0, RFC_KEY);
        repeat (299) tick();
        chk("mid_busy", 128'(b1.busy), 128'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_busy", 128'(b1.busy), 128'd0);
        chk("mr_kv", 128'(b1.keys_valid), 128'd0);
        chk("mr_done", 128'(b1.done), 128'd0);
        chk("mr_rk_o", b1.rk_o, 128'd0);
        read_rk(1, 4'd1, v);
        chk("mr_k2_cleared", v, 128'd0);
        run_key(1, RFC_KEY, -1, '0, n, nb);
        chk("mr_latency", 128'(n), 128'd545);
        check_keys(1, "mr_rfc", rfc_m);

        // random keys against the model
        for (int r = 0; r < 3; r++) begin
            key_a = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
            model(key_a, ka);
            run_key(1, key_a, -1, '0, n, nb);
            chk($sformatf("rnd%0d_latency", r), 128'(n), 128'd545);
            check_keys(1, $sformatf("rnd%0d", r), ka);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
